// File: rtl/accel_mailbox_if.sv
// Purpose : accelerator-side mailbox; snoops CPU command writes, fetches a 512-bit block, runs the hash core, writes digest + status back.
// Latency : command edge N -> busy status write in N+1, core_start in N+4; core_done edge M -> digest M+1..M+8, status M+9, idle M+10.
// Backpress: none; memory port is fixed-latency, a go while busy is dropped and flagged in the overflow bit.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_wrt_en/cpu_addr/cpu_wrt_data snooped CPU data-memory write bus
//   accel_rd_data                   16 words at accel_addr, valid one cycle after the address
//   accel_addr/accel_wrt_data/accel_wrt_en  shared read/write port into CPU data memory
//   core_block/core_start           message block and one-cycle start pulse to the hash core
//   core_done/core_digest           hash core completion and 256-bit digest
module accel_mailbox_if #(
  parameter logic [15:0] CMD_ADDR    = 16'hFF00,
  parameter logic [15:0] STATUS_ADDR = 16'hFF01,
  parameter logic [15:0] RESULT_ADDR = 16'hFF10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_wrt_en,
  input  logic [15:0]  cpu_addr,
  input  logic [31:0]  cpu_wrt_data,
  input  logic [511:0] accel_rd_data,
  output logic [15:0]  accel_addr,
  output logic [31:0]  accel_wrt_data,
  output logic         accel_wrt_en,
  output logic [511:0] core_block,
  output logic         core_start,
  input  logic         core_done,
  input  logic [255:0] core_digest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_FETCH,
    S_LATCH,
    S_START,
    S_WAIT,
    S_WRITE,
    S_STATUS
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    src_q, src_d;
  logic [255:0]   digest_q, digest_d;
  logic [511:0]   block_q, block_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    job_cnt_q, job_cnt_d;
  logic [2:0]     idx_q, idx_d;

  logic           cmd_hit;
  logic           cmd_go;
  logic           cmd_clr;
  logic [15:0]    job_cnt_inc;
  logic [31:0]    dig_word;
  logic           unused_cmd_bits;

  // Command word: [0] go, [1] clear overflow, [31:16] source address.
  assign cmd_hit         = cpu_wrt_en && (cpu_addr == CMD_ADDR);
  assign cmd_go          = cmd_hit && cpu_wrt_data[0];
  assign cmd_clr         = cmd_hit && cpu_wrt_data[1];
  assign unused_cmd_bits = ^cpu_wrt_data[15:2];

  assign job_cnt_inc = job_cnt_q + 16'd1;
  assign core_block  = block_q;

  // Digest is streamed most-significant word first.
  always_comb begin
    dig_word = 32'd0;
    for (int k = 0; k < 8; k++) begin
      if (idx_q == 3'(k)) begin
        dig_word = digest_q[255-32*k -: 32];
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    digest_d  = digest_q;
    block_d   = block_q;
    job_cnt_d = job_cnt_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_go) begin
          src_d   = cpu_wrt_data[31:16];
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: state_d = S_FETCH;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH: begin
        // Read data for the address presented in FETCH arrives in this cycle.
        block_d = accel_rd_data;
        state_d = S_START;
      end
      S_START:  state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          digest_d = core_digest;
          idx_d    = 3'd0;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = S_STATUS;
        end
      end
      S_STATUS: begin
        job_cnt_d = job_cnt_inc;
        state_d   = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase

    // A go that cannot be accepted sets overflow and beats a clear in the same write.
    if (cmd_go && (state_q != S_IDLE)) begin
      ovf_d = 1'b1;
    end else if (cmd_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    accel_addr     = 16'd0;
    accel_wrt_data = 32'd0;
    accel_wrt_en   = 1'b0;
    core_start     = 1'b0;

    case (state_q)
      S_ACCEPT: begin
        accel_wrt_en   = 1'b1;
        accel_addr     = STATUS_ADDR;
        accel_wrt_data = {job_cnt_q, 13'd0, ovf_q, 1'b0, 1'b1};
      end
      S_FETCH, S_LATCH: begin
        accel_addr = src_q;
      end
      S_START: begin
        core_start = 1'b1;
      end
      S_WRITE: begin
        accel_wrt_en   = 1'b1;
        accel_addr     = RESULT_ADDR + {13'd0, idx_q};
        accel_wrt_data = dig_word;
      end
      S_STATUS: begin
        // Status carries the count that includes the job just finished.
        accel_wrt_en   = 1'b1;
        accel_addr     = STATUS_ADDR;
        accel_wrt_data = {job_cnt_inc, 13'd0, ovf_q, 1'b1, 1'b0};
      end
      default: begin
        accel_addr = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_q     <= 16'd0;
      digest_q  <= 256'd0;
      block_q   <= 512'd0;
      ovf_q     <= 1'b0;
      job_cnt_q <= 16'd0;
      idx_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      digest_q  <= digest_d;
      block_q   <= block_d;
      ovf_q     <= ovf_d;
      job_cnt_q <= job_cnt_d;
      idx_q     <= idx_d;
    end
  end

endmodule
